// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] INSTR_TERMINATOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs; flush dominates push/pop.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Storage, pointers and occupancy; storage is cleared on reset so the head reads zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '{default: '0};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: drives the ROM address, buffers fetched words, hands them to decode.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_enable,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rd,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic            halted
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t        state_q;
    fetch_state_t        state_d;
    logic [XLEN-1:0]     fetch_pc;
    logic                push;
    logic                pop;
    logic                room;
    logic [2*XLEN-1:0]   head;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    assign imem_addr   = fetch_pc;
    assign pop         = instr_valid & instr_ready;
    assign room        = ~fifo_full | pop;
    assign instr_valid = ~fifo_empty;
    assign instr_pc    = head[2*XLEN-1:XLEN];
    assign instr       = head[XLEN-1:0];
    assign halted      = (state_q == HALT) & (fifo_count == '0);

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({fetch_pc, imem_rd}),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and push decision; a redirect overrides everything else.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        if (redirect_valid) begin
            state_d = fetch_enable ? RUN : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fetch_enable) state_d = RUN;
                end
                RUN: begin
                    push = (imem_rd != INSTR_TERMINATOR) & room;
                    if (!fetch_enable)                     state_d = IDLE;
                    else if (imem_rd == INSTR_TERMINATOR)  state_d = HALT;
                end
                HALT: begin
                    state_d = HALT;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Fetch PC: redirect target is word aligned; otherwise advance on every accepted push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (push) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: queue-based reference model plus directed literal checks.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;

    logic [31:0] imem_addr, imem_rd, instr, instr_pc;
    logic        instr_valid, halted;

    logic [31:0] imem_addr2, imem_rd2, instr2, instr_pc2;
    logic        instr_valid2, halted2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom = 32'h0050_0113;
            32'h0000_0004: rom = 32'h00c0_0193;
            32'h0000_0008: rom = 32'hFF71_8393;
            32'h0000_002C: rom = 32'h0010_0093;
            32'h0000_0030: rom = 32'h0020_0113;
            32'hFFFF_FFFC: rom = 32'h0000_0013;
            default:       rom = 32'h0000_0000;
        endcase
    endfunction

    assign imem_rd  = rom(imem_addr);
    assign imem_rd2 = rom(imem_addr2);

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .fetch_enable(fetch_enable),
        .imem_addr(imem_addr), .imem_rd(imem_rd),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .halted(halted)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .reset(reset), .fetch_enable(fetch_enable),
        .imem_addr(imem_addr2), .imem_rd(imem_rd2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2),
        .instr_ready(instr_ready), .halted(halted2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of fetched {pc, word} pairs, a fetch pointer and a run mode.
    logic [63:0] q[$];
    logic [31:0] m_pc;
    int          m_mode;   // 0 stopped, 1 fetching, 2 terminator seen

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_pc   = 32'h0000_0000;
            m_mode = 0;
        end else begin
            bit          consumed;
            bit          space;
            logic [31:0] word;
            consumed = (q.size() > 0) && instr_ready;
            word     = rom(m_pc);
            if (redirect_valid) begin
                q.delete();
                m_pc   = redirect_pc & 32'hFFFF_FFFC;
                m_mode = fetch_enable ? 1 : 0;
            end else begin
                space = (q.size() < 2) || consumed;
                if (consumed) void'(q.pop_front());
                if (m_mode == 1 && word != 32'h0 && space) begin
                    q.push_back({m_pc, word});
                    m_pc = m_pc + 32'd4;
                end
                if (m_mode == 0 && fetch_enable)      m_mode = 1;
                else if (m_mode == 1 && !fetch_enable) m_mode = 0;
                else if (m_mode == 1 && word == 32'h0) m_mode = 2;
            end
        end
    end

    // Every falling edge: the DUT must agree with the model.
    always @(negedge clk) begin
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, q.size() > 0});
        chk("halted", {31'b0, halted}, {31'b0, (m_mode == 2) && (q.size() == 0)});
        if (q.size() > 0) begin
            chk("instr", instr, q[0][31:0]);
            chk("instr_pc", instr_pc, q[0][63:32]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_pc    = target;
        redirect_valid = 1'b1;
        cyc(1);
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fetch_enable = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; instr_ready = 1'b1;
        cyc(2);
        reset = 1'b0;
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_addr_wrap", imem_addr2, 32'hFFFF_FFFC);

        // Sequential fetch to the terminator.
        fetch_enable = 1'b1;
        cyc(1);
        chk("seq_c1_valid", {31'b0, instr_valid}, 32'd0);
        cyc(1);
        chk("seq_pc0", instr_pc, 32'h0);
        chk("seq_i0", instr, 32'h0050_0113);
        chk("wrap_addr", imem_addr2, 32'h0000_0000);
        chk("wrap_head", instr_pc2, 32'hFFFF_FFFC);
        cyc(1);
        chk("seq_pc4", instr_pc, 32'h4);
        cyc(1);
        chk("seq_pc8", instr_pc, 32'h8);
        chk("seq_i8", instr, 32'hFF71_8393);
        cyc(1);
        chk("seq_halted", {31'b0, halted}, 32'd1);
        chk("seq_addr_hold", imem_addr, 32'hC);

        // Redirect out of HALT.
        do_redirect(32'h0);
        chk("hr_halted", {31'b0, halted}, 32'd0);
        cyc(1);
        chk("hr_pc0", instr_pc, 32'h0);
        chk("hr_i0", instr, 32'h0050_0113);
        cyc(3);
        chk("hr_halted2", {31'b0, halted}, 32'd1);

        // Backpressure: decode stalls five cycles after the first valid.
        instr_ready = 1'b0;
        do_redirect(32'h0);
        cyc(1);
        cyc(5);
        chk("bp_addr", imem_addr, 32'h8);
        chk("bp_head", instr_pc, 32'h0);
        chk("bp_instr", instr, 32'h0050_0113);
        instr_ready = 1'b1;
        cyc(1);
        chk("bp_pc4", instr_pc, 32'h4);
        cyc(1);
        chk("bp_pc8", instr_pc, 32'h8);
        cyc(1);
        chk("bp_halted", {31'b0, halted}, 32'd1);

        // Redirect while the FIFO holds pc 4 and 8; unaligned target.
        instr_ready = 1'b0;
        do_redirect(32'h0);
        cyc(2);
        instr_ready = 1'b1;
        cyc(1);
        chk("rd_pre_head", instr_pc, 32'h4);
        instr_ready = 1'b0;
        do_redirect(32'h2E);
        chk("rd_flush", {31'b0, instr_valid}, 32'd0);
        chk("rd_addr", imem_addr, 32'h2C);
        cyc(1);
        chk("rd_head", instr_pc, 32'h2C);
        chk("rd_instr", instr, 32'h0010_0093);
        instr_ready = 1'b1;
        cyc(3);
        chk("rd_halted", {31'b0, halted}, 32'd1);

        // fetch_enable dropped mid-run: PC retained, FIFO drains.
        instr_ready = 1'b0;
        do_redirect(32'h0);
        cyc(1);
        fetch_enable = 1'b0;
        cyc(3);
        chk("en_addr", imem_addr, 32'h8);
        instr_ready = 1'b1;
        cyc(2);
        chk("en_drained", {31'b0, instr_valid}, 32'd0);
        chk("en_addr2", imem_addr, 32'h8);

        // Asynchronous reset between clock edges.
        fetch_enable = 1'b1;
        cyc(3);
        #3 reset = 1'b1;
        #1;
        chk("ar_valid", {31'b0, instr_valid}, 32'd0);
        chk("ar_halted", {31'b0, halted}, 32'd0);
        chk("ar_addr", imem_addr, 32'h0);
        chk("ar_addr_wrap", imem_addr2, 32'hFFFF_FFFC);
        @(posedge clk);
        #3 reset = 1'b0;
        cyc(2);
        chk("ar_restart", instr_pc, 32'h0);
        chk("ar_restart_v", {31'b0, instr_valid}, 32'd1);
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
